// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWRITE,
        S_MEMWB,
        S_EXECUTER,
        S_EXECUTEI,
        S_JAL,
        S_BEQ,
        S_LUI,
        S_ALUWB,
        S_FAULT
    } state_e;

    // ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Operand / result selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Opcodes
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // Trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: operation class plus funct fields to ALU control code.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_b5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Select ADD/SUB directly, or decode funct3 for R/I arithmetic
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM with memory wait states, timeout watchdog and illegal-opcode trap.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_WIDTH = 3,
    parameter int unsigned MEM_HANDSHAKE  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                op,
    input  logic [2:0]                funct3,
    input  logic                      funct7b5,
    input  logic                      zero,
    input  logic                      mem_ready,
    output logic                      mem_req,
    output logic                      mem_write,
    output logic                      adr_src,
    output logic                      ir_write,
    output logic                      pc_write,
    output logic                      reg_write,
    output logic [1:0]                result_src,
    output logic [1:0]                alu_src_a,
    output logic [1:0]                alu_src_b,
    output logic [2:0]                imm_src,
    output logic [ALU_CTRL_WIDTH-1:0] alu_control,
    output logic                      fault,
    output logic [1:0]                fault_cause
);

    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIM = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    state_e                   state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic                     fault_q, fault_d;
    logic [1:0]               cause_q, cause_d;

    logic       ready_eff;
    logic       timeout_hit;
    logic       mem_state;
    logic [1:0] trap_cause;
    logic [1:0] alu_op;
    logic [2:0] alu_code;
    logic       mem_req_raw, mem_write_raw, ir_write_raw, pc_write_raw, reg_write_raw;

    assign ready_eff   = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == TIMEOUT_LIM);
    assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

    // State, watchdog and trap registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
            cause_q    <= CAUSE_NONE;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
            cause_q    <= cause_d;
        end
    end

    // Next state and per-state control outputs
    always_comb begin
        state_d       = state_q;
        trap_cause    = CAUSE_NONE;
        mem_req_raw   = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        adr_src       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        imm_src       = IMM_I;
        alu_op        = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_raw  = 1'b1;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALU;
                ir_write_raw = ready_eff;
                pc_write_raw = ready_eff;
                if (ready_eff)        state_d = S_DECODE;
                else if (timeout_hit) begin state_d = S_FAULT; trap_cause = CAUSE_TIMEOUT; end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_LUI:       state_d = S_LUI;
                    default: begin state_d = S_FAULT; trap_cause = CAUSE_ILLEGAL; end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (op == OP_LW) ? IMM_I : IMM_S;
                state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req_raw = 1'b1;
                adr_src     = 1'b1;
                if (ready_eff)        state_d = S_MEMWB;
                else if (timeout_hit) begin state_d = S_FAULT; trap_cause = CAUSE_TIMEOUT; end
            end
            S_MEMWRITE: begin
                mem_req_raw   = 1'b1;
                mem_write_raw = 1'b1;
                adr_src       = 1'b1;
                if (ready_eff)        state_d = S_FETCH;
                else if (timeout_hit) begin state_d = S_FAULT; trap_cause = CAUSE_TIMEOUT; end
            end
            S_MEMWB: begin
                reg_write_raw = 1'b1;
                result_src    = RES_DATA;
                state_d       = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
                state_d   = S_ALUWB;
            end
            S_JAL: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                pc_write_raw = 1'b1;
                state_d      = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a    = SRCA_RS1;
                alu_op       = ALUOP_SUB;
                pc_write_raw = zero;
                state_d      = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // Wait counter tracks stalled memory cycles; trap flags latch on entry to FAULT
    always_comb begin
        wait_cnt_d = '0;
        if (mem_state && !ready_eff)
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
        fault_d = fault_q;
        cause_d = cause_q;
        if (state_d == S_FAULT && state_q != S_FAULT) begin
            fault_d = 1'b1;
            cause_d = trap_cause;
        end
    end

    mc_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op_b5       (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_code)
    );

    // Strobes are gated by rst_n so nothing fires while reset is held, even though FETCH is the reset state
    assign mem_req     = mem_req_raw   & rst_n;
    assign mem_write   = mem_write_raw & rst_n;
    assign ir_write    = ir_write_raw  & rst_n;
    assign pc_write    = pc_write_raw  & rst_n;
    assign reg_write   = reg_write_raw & rst_n;
    assign alu_control = ALU_CTRL_WIDTH'(alu_code);
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [2:0] alu_control;
    logic       fault;
    logic [1:0] fault_cause;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_control #(
        .ALU_CTRL_WIDTH (3),
        .MEM_HANDSHAKE  (1),
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_WIDTH  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_write   (mem_write),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .fault       (fault),
        .fault_cause (fault_cause)
    );

    always #5 clk = ~clk;

    logic [4:0] en;
    logic [7:0] sel;
    assign en  = {mem_req, mem_write, ir_write, pc_write, reg_write};
    assign sel = {adr_src, alu_src_a, alu_src_b, imm_src};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++; if (dut.state_q !== S_FETCH) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, S_FETCH); end
        n_checks++; if (en !== 5'b00000) begin n_fail++; $display("FAIL reset_enables: got %b want 00000", en); end
        n_checks++; if ({fault, fault_cause} !== 3'b000) begin n_fail++; $display("FAIL reset_fault: got %b want 000", {fault, fault_cause}); end
        n_checks++; if (dut.wait_cnt_q !== 8'd0) begin n_fail++; $display("FAIL reset_wait_cnt: got %0d want 0", dut.wait_cnt_q); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (en !== 5'b10110) begin n_fail++; $display("FAIL reset_release_fetch: got %b want 10110", en); end
    endtask

    task automatic test_lw();
        state_e     exp_st[5]  = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
        logic [4:0] exp_en[5]  = '{5'b10110, 5'b00000, 5'b00000, 5'b10000, 5'b00001};
        logic [7:0] exp_sel[5] = '{8'b0_00_10_000, 8'b0_01_01_010, 8'b0_10_01_000, 8'b1_00_00_000, 8'b0_00_00_000};
        logic [1:0] exp_res[5] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
        op = OP_LW; mem_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (dut.state_q !== exp_st[i]) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, dut.state_q, exp_st[i]); end
            n_checks++; if (en !== exp_en[i]) begin n_fail++; $display("FAIL lw_enables[%0d]: got %b want %b", i, en, exp_en[i]); end
            n_checks++; if (sel !== exp_sel[i]) begin n_fail++; $display("FAIL lw_selects[%0d]: got %b want %b", i, sel, exp_sel[i]); end
            n_checks++; if (result_src !== exp_res[i]) begin n_fail++; $display("FAIL lw_result_src[%0d]: got %b want %b", i, result_src, exp_res[i]); end
            tick();
        end
        n_checks++; if (dut.state_q !== S_FETCH) begin n_fail++; $display("FAIL lw_return: got %0d want %0d", dut.state_q, S_FETCH); end
    endtask

    task automatic test_beq();
        logic zv[2] = '{1'b1, 1'b0};
        op = OP_BEQ; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            zero = zv[i];
            tick();
            tick();
            n_checks++; if (dut.state_q !== S_BEQ) begin n_fail++; $display("FAIL beq_state[z=%0b]: got %0d want %0d", zv[i], dut.state_q, S_BEQ); end
            n_checks++; if (pc_write !== zv[i]) begin n_fail++; $display("FAIL beq_pc_write[z=%0b]: got %b want %b", zv[i], pc_write, zv[i]); end
            n_checks++; if (alu_control !== ALU_SUB) begin n_fail++; $display("FAIL beq_alu[z=%0b]: got %b want 001", zv[i], alu_control); end
            n_checks++; if ({alu_src_a, alu_src_b, result_src} !== 6'b10_00_00) begin n_fail++; $display("FAIL beq_selects: got %b want 100000", {alu_src_a, alu_src_b, result_src}); end
            tick();
            n_checks++; if (dut.state_q !== S_FETCH) begin n_fail++; $display("FAIL beq_return[z=%0b]: got %0d want %0d", zv[i], dut.state_q, S_FETCH); end
        end
        zero = 1'b0;
    endtask

    task automatic test_funct_decode();
        logic [6:0] t_op[6]  = '{OP_R,    OP_R,    OP_R,    OP_R,    OP_I,    OP_R};
        logic [2:0] t_f3[6]  = '{3'b000,  3'b111,  3'b010,  3'b000,  3'b000,  3'b110};
        logic       t_f7[6]  = '{1'b1,    1'b0,    1'b0,    1'b0,    1'b1,    1'b0};
        logic [2:0] t_alu[6] = '{ALU_SUB, ALU_AND, ALU_SLT, ALU_ADD, ALU_ADD, ALU_OR};
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            op = t_op[i]; funct3 = t_f3[i]; funct7b5 = t_f7[i];
            tick();
            tick();
            n_checks++; if (dut.state_q !== ((t_op[i] == OP_R) ? S_EXECUTER : S_EXECUTEI)) begin n_fail++; $display("FAIL funct_state[%0d]: got %0d", i, dut.state_q); end
            n_checks++; if (alu_control !== t_alu[i]) begin n_fail++; $display("FAIL funct_alu[%0d]: got %b want %b", i, alu_control, t_alu[i]); end
            tick();
            n_checks++; if ({dut.state_q == S_ALUWB, reg_write, result_src} !== 4'b1_1_00) begin n_fail++; $display("FAIL funct_aluwb[%0d]: state %0d reg_write %b result_src %b", i, dut.state_q, reg_write, result_src); end
            tick();
        end
        funct3 = 3'd0; funct7b5 = 1'b0;
    endtask

    task automatic test_latency();
        logic [6:0] t_op[7]  = '{OP_R, OP_I, OP_LUI, OP_JAL, OP_SW, OP_LW, OP_BEQ};
        int         t_lat[7] = '{4, 4, 4, 4, 4, 5, 3};
        int         cnt;
        mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            op = t_op[i];
            cnt = 0;
            do begin
                tick();
                cnt++;
            end while (dut.state_q != S_FETCH && cnt < 20);
            n_checks++; if (cnt != t_lat[i]) begin n_fail++; $display("FAIL latency[op=%b]: got %0d want %0d", t_op[i], cnt, t_lat[i]); end
        end
    endtask

    task automatic test_fetch_wait();
        op = OP_BEQ; zero = 1'b0; mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (dut.state_q !== S_FETCH || {ir_write, pc_write} !== 2'b00) begin n_fail++; $display("FAIL fetch_wait[%0d]: state %0d ir/pc %b want FETCH 00", i, dut.state_q, {ir_write, pc_write}); end
            n_checks++; if (dut.wait_cnt_q !== 8'(i)) begin n_fail++; $display("FAIL fetch_wait_cnt[%0d]: got %0d want %0d", i, dut.wait_cnt_q, i); end
            tick();
        end
        mem_ready = 1'b1;
        #1;
        n_checks++; if ({ir_write, pc_write} !== 2'b11) begin n_fail++; $display("FAIL fetch_ready: ir/pc got %b want 11", {ir_write, pc_write}); end
        tick();
        n_checks++; if (dut.state_q !== S_DECODE || {ir_write, pc_write} !== 2'b00 || dut.wait_cnt_q !== 8'd0) begin n_fail++; $display("FAIL fetch_after: state %0d ir/pc %b wait %0d want DECODE 00 0", dut.state_q, {ir_write, pc_write}, dut.wait_cnt_q); end
        tick();
        tick();
    endtask

    task automatic test_illegal();
        op = 7'b0000000; mem_ready = 1'b1;
        tick();
        n_checks++; if (dut.state_q !== S_DECODE || fault !== 1'b0) begin n_fail++; $display("FAIL illegal_decode: state %0d fault %b", dut.state_q, fault); end
        tick();
        n_checks++; if (dut.state_q !== S_FAULT || {fault, fault_cause} !== 3'b1_01) begin n_fail++; $display("FAIL illegal_fault: state %0d fault/cause %b want FAULT 101", dut.state_q, {fault, fault_cause}); end
        op = OP_R;
        tick();
        tick();
        n_checks++; if (dut.state_q !== S_FAULT || en !== 5'b00000 || {fault, fault_cause} !== 3'b1_01) begin n_fail++; $display("FAIL illegal_absorb: state %0d en %b fault/cause %b", dut.state_q, en, {fault, fault_cause}); end
        do_reset();
        n_checks++; if (dut.state_q !== S_FETCH || {fault, fault_cause} !== 3'b000) begin n_fail++; $display("FAIL illegal_recover: state %0d fault/cause %b", dut.state_q, {fault, fault_cause}); end
    endtask

    task automatic test_timeout();
        op = OP_LW; mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i <= 8; i++) begin
            n_checks++; if (dut.state_q !== S_MEMREAD || dut.wait_cnt_q !== 8'(i) || fault !== 1'b0) begin n_fail++; $display("FAIL timeout_wait[%0d]: state %0d wait %0d fault %b", i, dut.state_q, dut.wait_cnt_q, fault); end
            tick();
        end
        n_checks++; if (dut.state_q !== S_FAULT || {fault, fault_cause} !== 3'b1_10) begin n_fail++; $display("FAIL timeout_fault: state %0d fault/cause %b want FAULT 110", dut.state_q, {fault, fault_cause}); end
        n_checks++; if (en !== 5'b00000) begin n_fail++; $display("FAIL timeout_enables: got %b want 00000", en); end
        mem_ready = 1'b1;
        do_reset();
    endtask

    task automatic test_reset_mid_store();
        op = OP_SW; mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        n_checks++; if (dut.state_q !== S_MEMWRITE || {mem_req, mem_write, adr_src} !== 3'b111) begin n_fail++; $display("FAIL store_wait: state %0d req/wr/adr %b", dut.state_q, {mem_req, mem_write, adr_src}); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({mem_req, mem_write} !== 2'b00) begin n_fail++; $display("FAIL store_reset_strobes: got %b want 00", {mem_req, mem_write}); end
        n_checks++; if (dut.state_q !== S_FETCH || dut.wait_cnt_q !== 8'd0 || fault !== 1'b0) begin n_fail++; $display("FAIL store_reset_state: state %0d wait %0d fault %b", dut.state_q, dut.wait_cnt_q, fault); end
        mem_ready = 1'b1;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_beq();
        test_funct_decode();
        test_latency();
        test_fetch_wait();
        test_illegal();
        test_timeout();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
